// File: rtl/adc_capture_pipe.sv
// adc_capture_pipe: multi-channel ADC capture engine feeding a first-word-fall-through
// buffer of 16-bit channel-tagged words, drained by an okPipeOut endpoint.
// Optional build macro: ADC_TEST_PATTERN_EN replaces captured codes with a per-set ramp.
module adc_capture_pipe #(
   parameter int PRECISION  = 10,
   parameter int CHANNELS   = 2,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          soft_clear,
   input  logic                          arm,
   input  logic                          trig_sel,
   input  logic                          trig_ext,
   input  logic [PRECISION-1:0]          trig_level,
   input  logic [15:0]                   capture_len,
   input  logic                          sample_valid,
   input  logic [CHANNELS*PRECISION-1:0] sample_data,
   input  logic                          rd_en,
   output logic [15:0]                   rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [DEPTH_LOG2:0]           fill_count,
   output logic [1:0]                    state,
   output logic                          done,
   output logic                          overrun,
   output logic                          underflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t                  cur_state;
   state_t                  next_state;
   logic                    prev_ext;
   logic [PRECISION-1:0]    prev_ch0;
   logic [PRECISION-1:0]    ch0;
   logic [15:0]             set_count;
   logic                    busy;
   logic [IDX_W-1:0]        ser_idx;
   logic [PRECISION-1:0]    hold [CHANNELS];
   logic [PRECISION-1:0]    load_code [CHANNELS];
   logic                    ext_fire;
   logic                    level_fire;
   logic                    sets_left;
   logic                    cap_want;
   logic                    ser_ready;
   logic                    accept;
   logic                    drop_set;
   logic                    capture_complete;
   logic [15:0]             wr_word;
   logic                    wr_ok;
   logic                    pop;
   logic [15:0]             mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic [DEPTH_LOG2-1:0]   rd_ptr;

   // The serialiser can take a new set on the same edge it writes the last word of the old one.
   assign ch0              = sample_data[PRECISION-1:0];
   assign ext_fire         = (cur_state == ST_ARMED) && !trig_sel && trig_ext && !prev_ext;
   assign level_fire       = (cur_state == ST_ARMED) && trig_sel && sample_valid &&
                             (prev_ch0 < trig_level) && (ch0 >= trig_level);
   assign sets_left        = (capture_len == 16'd0) || (set_count < capture_len);
   assign cap_want         = (cur_state == ST_CAPTURE) && sample_valid && sets_left;
   assign ser_ready        = !busy || (ser_idx == LAST_IDX);
   assign accept           = level_fire || (cap_want && ser_ready);
   assign drop_set         = cap_want && !ser_ready;
   assign capture_complete = (capture_len != 16'd0) && (set_count >= capture_len) && !busy;

   // State register; soft_clear returns to IDLE like a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cur_state <= ST_IDLE;
      else if (soft_clear)
         cur_state <= ST_IDLE;
      else
         cur_state <= next_state;
   end

   // Next-state logic: arm is only honoured in IDLE and DONE; continuous capture never finishes.
   always_comb begin
      next_state = cur_state;
      case (cur_state)
         ST_IDLE:    if (arm) next_state = ST_ARMED;
         ST_ARMED:   if (ext_fire || level_fire) next_state = ST_CAPTURE;
         ST_CAPTURE: if (capture_complete) next_state = ST_DONE;
         ST_DONE:    if (arm) next_state = ST_ARMED;
         default:    next_state = ST_IDLE;
      endcase
   end

   // Trigger history and accepted-set counter; the level-trigger crossing set counts as the first set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_ext  <= 1'b0;
         prev_ch0  <= '0;
         set_count <= '0;
      end else if (soft_clear) begin
         prev_ext  <= 1'b0;
         prev_ch0  <= '0;
         set_count <= '0;
      end else begin
         prev_ext <= trig_ext;
         if (sample_valid)
            prev_ch0 <= ch0;
         if (ext_fire)
            set_count <= '0;
         else if (level_fire)
            set_count <= 16'd1;
         else if (accept && (set_count != 16'hFFFF))
            set_count <= set_count + 16'd1;
      end
   end

`ifdef ADC_TEST_PATTERN_EN
   logic [PRECISION-1:0] ramp;
   logic [PRECISION-1:0] ramp_now;

   // Ramp restarts at zero on entry to CAPTURE; a level-trigger crossing set consumes ramp value 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ramp <= '0;
      else if (soft_clear)
         ramp <= '0;
      else if (ext_fire)
         ramp <= '0;
      else if (level_fire)
         ramp <= PRECISION'(1);
      else if (accept)
         ramp <= ramp + PRECISION'(1);
   end

   assign ramp_now = level_fire ? '0 : ramp;

   // Synthetic codes replace the ADC data: channel k carries ramp + k.
   always_comb begin
      for (int k = 0; k < CHANNELS; k++)
         load_code[k] = ramp_now + PRECISION'(k);
   end
`else
   // Captured codes come straight from the ADC bus.
   always_comb begin
      for (int k = 0; k < CHANNELS; k++)
         load_code[k] = sample_data[k*PRECISION +: PRECISION];
   end
`endif

   // Holding register and channel index: one word per cycle after a set is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= 1'b0;
         ser_idx <= '0;
         for (int k = 0; k < CHANNELS; k++) hold[k] <= '0;
      end else if (soft_clear) begin
         busy    <= 1'b0;
         ser_idx <= '0;
         for (int k = 0; k < CHANNELS; k++) hold[k] <= '0;
      end else if (accept) begin
         busy    <= 1'b1;
         ser_idx <= '0;
         for (int k = 0; k < CHANNELS; k++) hold[k] <= load_code[k];
      end else if (busy) begin
         if (ser_idx == LAST_IDX)
            busy <= 1'b0;
         else
            ser_idx <= ser_idx + IDX_W'(1);
      end
   end

   // Word format: channel tag in the top nibble, code right-aligned, zero in between.
   always_comb begin
      wr_word                = '0;
      wr_word[15:12]         = 4'(ser_idx);
      wr_word[PRECISION-1:0] = hold[ser_idx];
   end

   assign wr_ok = busy && !full;
   assign pop   = rd_en && !empty;

   // Buffer storage; contents need no reset because the head is masked while empty.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= wr_word;
   end

   // Buffer pointers and occupancy; pointers wrap naturally at the buffer depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_count <= '0;
      end else if (soft_clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_count <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop)
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         case ({wr_ok, pop})
            2'b10:   fill_count <= fill_count + (DEPTH_LOG2+1)'(1);
            2'b01:   fill_count <= fill_count - (DEPTH_LOG2+1)'(1);
            default: fill_count <= fill_count;
         endcase
      end
   end

   // Sticky error flags for the host: dropped set/word and reads from an empty buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun   <= 1'b0;
         underflow <= 1'b0;
      end else if (soft_clear) begin
         overrun   <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overrun   <= overrun | drop_set | (busy && full);
         underflow <= underflow | (rd_en && empty);
      end
   end

   assign empty   = (fill_count == '0);
   assign full    = (fill_count == FULL_COUNT);
   assign rd_data = empty ? 16'h0000 : mem[rd_ptr];
   assign state   = cur_state;
   assign done    = (cur_state == ST_DONE);

endmodule

// File: tb/tb_adc_capture_pipe.sv
// tb_adc_capture_pipe: directed sequences plus randomized traffic against a queue-based model.
// Build with ADC_TEST_PATTERN_EN defined to exercise the ramp test-pattern variant.
module tb_adc_capture_pipe;

   localparam int PREC  = 10;
   localparam int CH    = 2;
   localparam int DL2   = 4;
   localparam int DEPTH = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              soft_clear;
   logic              arm;
   logic              trig_sel;
   logic              trig_ext;
   logic [PREC-1:0]   trig_level;
   logic [15:0]       capture_len;
   logic              sample_valid;
   logic [CH*PREC-1:0] sample_data;
   logic              rd_en;
   logic [15:0]       rd_data;
   logic              empty;
   logic              full;
   logic [DL2:0]      fill_count;
   logic [1:0]        state;
   logic              done;
   logic              overrun;
   logic              underflow;

   int checks   = 0;
   int failures = 0;

   adc_capture_pipe #(.PRECISION(PREC), .CHANNELS(CH), .DEPTH_LOG2(DL2)) dut (
      .clk(clk), .rst_n(rst_n), .soft_clear(soft_clear), .arm(arm),
      .trig_sel(trig_sel), .trig_ext(trig_ext), .trig_level(trig_level),
      .capture_len(capture_len), .sample_valid(sample_valid), .sample_data(sample_data),
      .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
      .fill_count(fill_count), .state(state), .done(done),
      .overrun(overrun), .underflow(underflow)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Reference model: words scheduled by edge number, buffer held as a queue.
   typedef struct {
      int          due;
      logic [15:0] word;
   } pend_t;

   int              edge_num = 0;
   int              m_state;
   logic            m_prev_ext;
   logic [PREC-1:0] m_prev_ch0;
   int              m_count;
   int              m_ramp;
   int              busy_end;
   bit              m_ovr;
   bit              m_und;
   pend_t           pend[$];
   logic [15:0]     fifo[$];

   typedef struct {
      logic        rd;
      logic [15:0] exp_word;
      logic [DL2:0] exp_fill;
   } rd_vec_t;

   rd_vec_t t2_vec [6];

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_state    = 0;
      m_prev_ext = 1'b0;
      m_prev_ch0 = '0;
      m_count    = 0;
      m_ramp     = 0;
      busy_end   = 0;
      m_ovr      = 1'b0;
      m_und      = 1'b0;
      pend.delete();
      fifo.delete();
   endtask

   task automatic acceptSet();
      pend_t           p;
      logic [PREC-1:0] code;
      for (int k = 0; k < CH; k++) begin
`ifdef ADC_TEST_PATTERN_EN
         code = PREC'((m_ramp + k) % (1 << PREC));
`else
         code = sample_data[k*PREC +: PREC];
`endif
         p.due  = edge_num + 1 + k;
         p.word = {4'(k), 2'b00, code};
         pend.push_back(p);
      end
      m_ramp++;
      if (m_count < 65535) m_count++;
      busy_end = edge_num + CH;
   endtask

   task automatic modelStep();
      int          pre_size;
      bit          idle;
      bit          ready;
      bit          wr;
      logic [15:0] w;
      bit          ext_fire;
      bit          lvl_fire;
      bit          want;
      logic [PREC-1:0] c0;
      edge_num++;
      if (soft_clear) begin
         modelReset();
         return;
      end
      c0       = sample_data[PREC-1:0];
      pre_size = fifo.size();
      idle     = (pend.size() == 0);
      ready    = (edge_num >= busy_end);
      wr       = 1'b0;
      w        = '0;
      if (pend.size() > 0 && pend[0].due == edge_num) begin
         wr = 1'b1;
         w  = pend[0].word;
         void'(pend.pop_front());
      end
      if (rd_en && pre_size > 0) void'(fifo.pop_front());
      if (rd_en && pre_size == 0) m_und = 1'b1;
      if (wr) begin
         if (pre_size == DEPTH) m_ovr = 1'b1;
         else fifo.push_back(w);
      end
      ext_fire = (m_state == 1) && !trig_sel && trig_ext && !m_prev_ext;
      lvl_fire = (m_state == 1) && trig_sel && sample_valid && (m_prev_ch0 < trig_level) && (c0 >= trig_level);
      want     = (m_state == 2) && sample_valid && ((capture_len == 0) || (m_count < int'(capture_len)));
      case (m_state)
         0: if (arm) m_state = 1;
         1: begin
            if (lvl_fire) begin
               m_count = 0;
               m_ramp  = 0;
               acceptSet();
               m_state = 2;
            end else if (ext_fire) begin
               m_count = 0;
               m_ramp  = 0;
               m_state = 2;
            end
         end
         2: begin
            if (want) begin
               if (ready) acceptSet();
               else m_ovr = 1'b1;
            end else if (capture_len != 0 && m_count >= int'(capture_len) && idle) begin
               m_state = 3;
            end
         end
         default: if (arm) m_state = 1;
      endcase
      m_prev_ext = trig_ext;
      if (sample_valid) m_prev_ch0 = c0;
   endtask

   task automatic checkOutput();
      checkValue("state", 32'(state), 32'(m_state));
      checkValue("fill_count", 32'(fill_count), 32'(fifo.size()));
      checkValue("empty", 32'(empty), 32'(fifo.size() == 0));
      checkValue("full", 32'(full), 32'(fifo.size() == DEPTH));
      checkValue("rd_data", 32'(rd_data), (fifo.size() > 0) ? 32'(fifo[0]) : 32'h0);
      checkValue("done", 32'(done), 32'(m_state == 3));
      checkValue("overrun", 32'(overrun), 32'(m_ovr));
      checkValue("underflow", 32'(underflow), 32'(m_und));
   endtask

   task automatic applyStimulus(input logic sc, input logic a, input logic te, input logic sv,
                                input logic [PREC-1:0] c0, input logic [PREC-1:0] c1, input logic rd);
      soft_clear   = sc;
      arm          = a;
      trig_ext     = te;
      sample_valid = sv;
      sample_data  = {c1, c0};
      rd_en        = rd;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
   endtask

   task automatic idleCycles(input int count);
      for (int i = 0; i < count; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   initial begin
      logic [15:0] exp_word;
      logic [11:0] exp_code;
      int          ci;

`ifdef ADC_TEST_PATTERN_EN
      t2_vec[0] = '{1'b1, 16'h0000, 5'd6};
      t2_vec[1] = '{1'b1, 16'h1001, 5'd5};
      t2_vec[2] = '{1'b1, 16'h0001, 5'd4};
      t2_vec[3] = '{1'b1, 16'h1002, 5'd3};
      t2_vec[4] = '{1'b1, 16'h0002, 5'd2};
      t2_vec[5] = '{1'b1, 16'h1003, 5'd1};
`else
      t2_vec[0] = '{1'b1, 16'h0155, 5'd6};
      t2_vec[1] = '{1'b1, 16'h12AA, 5'd5};
      t2_vec[2] = '{1'b1, 16'h0156, 5'd4};
      t2_vec[3] = '{1'b1, 16'h12AA, 5'd3};
      t2_vec[4] = '{1'b1, 16'h0157, 5'd2};
      t2_vec[5] = '{1'b1, 16'h12AA, 5'd1};
`endif

      rst_n        = 1'b0;
      soft_clear   = 1'b0;
      arm          = 1'b0;
      trig_sel     = 1'b0;
      trig_ext     = 1'b0;
      trig_level   = '0;
      capture_len  = 16'd3;
      sample_valid = 1'b0;
      sample_data  = '0;
      rd_en        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkValue("reset_state", 32'(state), 32'd0);
      checkValue("reset_empty", 32'(empty), 32'd1);
      checkValue("reset_rd_data", 32'(rd_data), 32'h0);
      #3 rst_n = 1'b1;
      modelReset();

      $display("[TB] external-edge trigger, three sets");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      checkValue("t2_armed", 32'(state), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 1'b0);
      checkValue("t2_trig_set_skipped", 32'(fill_count), 32'd0);
      idleCycles(1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'(10'h155 + i), 10'h2AA, 1'b0);
         idleCycles(3);
      end
      idleCycles(2);
      checkValue("t2_state_done", 32'(state), 32'd3);
      checkValue("t2_done", 32'(done), 32'd1);
      for (int i = 0; i < 6; i++) begin
         checkValue("t2_word", 32'(rd_data), 32'(t2_vec[i].exp_word));
         checkValue("t2_fill", 32'(fill_count), 32'(t2_vec[i].exp_fill));
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, t2_vec[i].rd);
      end
      checkValue("t2_empty", 32'(empty), 32'd1);

      $display("[TB] level trigger");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      trig_sel    = 1'b1;
      trig_level  = 10'h200;
      capture_len = 16'd1;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'h100, 10'h0AB, 1'b0);
      idleCycles(3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'h1FF, 10'h0AB, 1'b0);
      idleCycles(3);
      checkValue("t3_still_armed", 32'(state), 32'd1);
      checkValue("t3_nothing_yet", 32'(fill_count), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'h200, 10'h0AB, 1'b0);
      idleCycles(3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'h300, 10'h0AB, 1'b0);
      idleCycles(3);
`ifdef ADC_TEST_PATTERN_EN
      checkValue("t3_first_word", 32'(rd_data), 32'h0000);
`else
      checkValue("t3_first_word", 32'(rd_data), 32'h0200);
`endif
      checkValue("t3_fill", 32'(fill_count), 32'd2);
      checkValue("t3_done", 32'(state), 32'd3);

      $display("[TB] back-to-back sets");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      trig_sel    = 1'b0;
      capture_len = 16'd0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      checkValue("t4_overrun_clear", 32'(overrun), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'h011, 10'h033, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'h022, 10'h044, 1'b0);
      idleCycles(4);
      checkValue("t4_fill", 32'(fill_count), 32'd2);
      checkValue("t4_overrun", 32'(overrun), 32'd1);
`ifdef ADC_TEST_PATTERN_EN
      checkValue("t4_head", 32'(rd_data), 32'h0000);
`else
      checkValue("t4_head", 32'(rd_data), 32'h0011);
`endif
      checkValue("t4_capturing", 32'(state), 32'd2);

      $display("[TB] fill to full, drain, underflow");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'(i), 10'(10'h100 + i), 1'b0);
         idleCycles(2);
      end
      idleCycles(2);
      checkValue("t5_full", 32'(full), 32'd1);
      checkValue("t5_fill", 32'(fill_count), 32'd16);
      checkValue("t5_overrun", 32'(overrun), 32'd1);
      for (int j = 0; j < 16; j++) begin
         ci = j % 2;
`ifdef ADC_TEST_PATTERN_EN
         exp_code = 12'((j / 2) + ci);
`else
         exp_code = (ci == 0) ? 12'(j / 2) : 12'(12'h100 + (j / 2));
`endif
         exp_word = {4'(ci), exp_code};
         checkValue("t5_drain_word", 32'(rd_data), 32'(exp_word));
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      end
      checkValue("t5_underflow_clear", 32'(underflow), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      checkValue("t5_empty_read", 32'(rd_data), 32'h0);
      checkValue("t5_underflow", 32'(underflow), 32'd1);
      checkValue("t5_empty", 32'(empty), 32'd1);

      $display("[TB] randomized traffic");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      for (int c = 0; c < 3000; c++) begin
         if (c % 100 == 0) begin
            capture_len = 16'($urandom_range(0, 5));
            trig_level  = PREC'($urandom_range(0, 1023));
         end
         if (c % 500 == 0) trig_sel = 1'($urandom_range(0, 1));
         applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                       PREC'($urandom), PREC'($urandom), $urandom_range(0, 2) == 0);
      end

      $display("[TB] asynchronous reset mid-capture");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      trig_sel    = 1'b0;
      capture_len = 16'd0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'h0F0, 10'h00F, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'h0F1, 10'h00E, 1'b0);
      idleCycles(2);
      #2 rst_n = 1'b0;
      #1;
      checkValue("t1_state", 32'(state), 32'd0);
      checkValue("t1_empty", 32'(empty), 32'd1);
      checkValue("t1_rd_data", 32'(rd_data), 32'h0);
      checkValue("t1_fill", 32'(fill_count), 32'd0);
      checkValue("t1_overrun", 32'(overrun), 32'd0);
      checkValue("t1_underflow", 32'(underflow), 32'd0);
      modelReset();
      #2 rst_n = 1'b1;
      idleCycles(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
